// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared types and helpers for the CPU-byte to SRAM-word bridge
package sram_bridge_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;
    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction
endpackage

// File: rtl/sram_lane_mux.sv
// sram_lane_mux: selects one byte lane out of a 32-bit word
module sram_lane_mux
    import sram_bridge_pkg::*;
(
    input  logic [LANES*BYTE_W-1:0] word,
    input  logic [1:0]              lane,
    output logic [BYTE_W-1:0]       sel
);
    assign sel = word[lane*BYTE_W +: BYTE_W];
endmodule

// File: rtl/sram_byte_bridge.sv
// sram_byte_bridge: byte-wide req/ack CPU port onto a 32-bit byte-enabled SRAM port
module sram_byte_bridge
    import sram_bridge_pkg::*;
#(
    parameter int WORD_AW      = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [WORD_AW+1:0]        cpu_addr,
    input  logic [BYTE_W-1:0]         cpu_wdata,
    output logic [BYTE_W-1:0]         cpu_rdata,
    output logic                      cpu_ack,
    output logic [WORD_AW-1:0]        sram_address,
    output logic [LANES-1:0]          sram_byteenable,
    output logic                      sram_chipselect,
    output logic                      sram_write,
    output logic [LANES*BYTE_W-1:0]   sram_writedata,
    output logic                      sram_clken,
    input  logic [LANES*BYTE_W-1:0]   sram_readdata
);
    state_t state;
    logic req_d, live, we;
    logic [WORD_AW+1:0] addr_q;
    logic [BYTE_W-1:0] wdata_q, sel;
    logic [1:0] cnt;
    logic accept, done_ok;
    assign accept  = state == IDLE && cpu_req && !req_d;
    // live drops for good once req falls mid-access, so a late re-rise never earns an ack
    assign done_ok = cpu_req && live;
    sram_lane_mux u_mux (.word(sram_readdata), .lane(addr_q[1:0]), .sel(sel));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            req_d           <= 1'b1;
            live            <= 1'b0;
            we              <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            cnt             <= '0;
            cpu_rdata       <= '0;
            cpu_ack         <= 1'b0;
            sram_address    <= '0;
            sram_byteenable <= '0;
            sram_chipselect <= 1'b0;
            sram_write      <= 1'b0;
            sram_writedata  <= '0;
            sram_clken      <= 1'b0;
        end else begin
            req_d           <= cpu_req;
            live            <= accept || (live && cpu_req);
            sram_clken      <= 1'b1;
            sram_chipselect <= state == ISSUE;
            sram_write      <= state == ISSUE && we;
            if (state == ISSUE) begin
                sram_address    <= addr_q[WORD_AW+1:2];
                sram_byteenable <= lane_onehot(addr_q[1:0]);
                sram_writedata  <= {LANES{wdata_q}};
            end
            case (state)
                IDLE: if (accept) begin
                    state   <= ISSUE;
                    we      <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end
                ISSUE: begin
                    state <= we ? DONE : RWAIT;
                    cnt   <= '0;
                end
                RWAIT: if (cnt == 2'(READ_LATENCY)) begin
                    cpu_rdata <= sel;
                    cpu_ack   <= done_ok;
                    state     <= done_ok ? DONE : IDLE;
                end else begin
                    cnt <= cnt + 2'd1;
                end
                DONE: begin
                    cpu_ack <= done_ok;
                    state   <= done_ok ? DONE : IDLE;
                end
            endcase
        end
    end
endmodule
